sdram_responder: RTL and testbench

SDRAM_RESPONDER -- requirements
Module: sdram_responder

---
 rtl/sdram_responder.sv | 136 +++++++++++++
 tb/tb_sdram_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: behavioural SDR SDRAM target with backing store and protocol checker
// Ports:
//   clk                         single clock, all state changes on its rising edge
//   init_n                      asynchronous active-low reset
//   SDRAM_CKE                   clock enable, commands ignored while low
//   SDRAM_nCS/nRAS/nCAS/nWE     command lines
//   SDRAM_BA, SDRAM_A           bank and row/column/mode address
//   SDRAM_DQML/DQMH             write byte masks (1 = masked)
//   SDRAM_DQ                    data bus, driven only during the read window
//   proto_err, err_code         sticky first protocol violation and its code
//   refresh_cnt                 wrapping count of AUTO_REFRESH commands
// Optional: define SDRAM_RESP_CHECK_EN to build the protocol checker; otherwise
// proto_err and err_code are tied to 0.
module sdram_responder #(
    parameter int MEM_AW  = 14,
    parameter int RCD_CYC = 2,
    parameter int RFC_CYC = 7
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        SDRAM_CKE,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [1:0]  SDRAM_BA,
    input  logic [11:0] SDRAM_A,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    inout  wire  [15:0] SDRAM_DQ,
    output logic        proto_err,
    output logic [3:0]  err_code,
    output logic [15:0] refresh_cnt
);
    logic [3:0]        cmd;
    logic              is_act, is_rd, is_wr, is_pre, is_ref, is_lmr;
    logic [3:0]        bank_act;
    logic [11:0]       bank_row [4];
    logic [2:0]        cl;
    logic [2:0]        rd_phase;
    logic [15:0]       rd_word;
    logic [15:0]       mem [2**MEM_AW];
    logic [21:0]       full_addr;
    logic [MEM_AW-1:0] addr;
    logic              win, dq_oe;
    assign cmd       = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    assign is_act    = SDRAM_CKE && cmd == 4'b0011;
    assign is_rd     = SDRAM_CKE && cmd == 4'b0101;
    assign is_wr     = SDRAM_CKE && cmd == 4'b0100;
    assign is_pre    = SDRAM_CKE && cmd == 4'b0010;
    assign is_ref    = SDRAM_CKE && cmd == 4'b0001;
    assign is_lmr    = SDRAM_CKE && cmd == 4'b0000;
    assign full_addr = {SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[7:0]};
    assign addr      = full_addr[MEM_AW-1:0];
    // rd_phase counts edges since the READ (1 right after it); the bus is
    // driven for phases CL..CL+1 and the window closes on the following edge
    assign win       = rd_phase != 3'd0;
    assign dq_oe     = win && rd_phase >= cl;
    assign SDRAM_DQ  = dq_oe ? rd_word : 16'hzzzz;
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            bank_act    <= '0;
            for (int i = 0; i < 4; i++) bank_row[i] <= '0;
            cl          <= 3'd2;
            rd_phase    <= '0;
            rd_word     <= '0;
            refresh_cnt <= '0;
        end else begin
            rd_phase <= (!win || rd_phase > cl) ? 3'd0 : rd_phase + 3'd1;
            if (is_rd) begin
                rd_phase <= 3'd1;
                rd_word  <= mem[addr];
            end
            if (is_wr) rd_phase <= 3'd0;
            if (is_lmr) cl <= (SDRAM_A[6:4] == 3'd3) ? 3'd3 : 3'd2;
            if (is_ref) refresh_cnt <= refresh_cnt + 16'd1;
            if (is_act) begin
                bank_act[SDRAM_BA] <= 1'b1;
                bank_row[SDRAM_BA] <= SDRAM_A;
            end
            if ((is_rd || is_wr) && SDRAM_A[10]) bank_act[SDRAM_BA] <= 1'b0;
            if (is_pre) bank_act <= SDRAM_A[10] ? 4'b0 : bank_act & ~(4'b1 << SDRAM_BA);
        end
    end
    // backing store keeps its contents across reset
    always_ff @(posedge clk) begin
        if (is_wr && init_n) begin
            if (!SDRAM_DQML) mem[addr][7:0]  <= SDRAM_DQ[7:0];
            if (!SDRAM_DQMH) mem[addr][15:8] <= SDRAM_DQ[15:8];
        end
    end
`ifdef SDRAM_RESP_CHECK_EN
    logic       is_cmd;
    logic [7:0] rcd [4];
    logic [7:0] rfc;
    logic       loaded;
    logic [9:1] viol;
    logic [3:0] first;
    assign is_cmd = SDRAM_CKE && !SDRAM_nCS && cmd != 4'b0111;
    always_comb begin
        viol[1] = is_lmr && SDRAM_A[6:4] != 3'd2 && SDRAM_A[6:4] != 3'd3;
        viol[2] = is_lmr && SDRAM_A[2:0] != 3'd0;
        viol[3] = is_act && bank_act[SDRAM_BA];
        viol[4] = (is_rd || is_wr) && !bank_act[SDRAM_BA];
        viol[5] = (is_rd || is_wr) && rcd[SDRAM_BA] != 8'd0;
        viol[6] = (is_rd || is_wr) && !loaded;
        viol[7] = is_wr && win;
        viol[8] = is_ref && |bank_act;
        viol[9] = is_cmd && rfc != 8'd0;
        first = 4'd0;
        // scanning downwards leaves the lowest asserted code in first
        for (int i = 9; i >= 1; i--) if (viol[i]) first = 4'(i);
    end
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int i = 0; i < 4; i++) rcd[i] <= '0;
            rfc       <= '0;
            loaded    <= 1'b0;
            proto_err <= 1'b0;
            err_code  <= '0;
        end else begin
            for (int i = 0; i < 4; i++) rcd[i] <= (rcd[i] != 8'd0) ? rcd[i] - 8'd1 : 8'd0;
            if (is_act) rcd[SDRAM_BA] <= 8'(RCD_CYC - 1);
            rfc <= is_ref ? 8'(RFC_CYC) : (rfc != 8'd0 ? rfc - 8'd1 : 8'd0);
            if (is_lmr) loaded <= 1'b1;
            if (!proto_err && first != 4'd0) begin
                proto_err <= 1'b1;
                err_code  <= first;
            end
        end
    end
`else
    assign proto_err = 1'b0;
    assign err_code  = 4'd0;
`endif
endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder: scoreboard bench for sdram_responder against a cycle-count reference model
module tb_sdram_responder;
    localparam int AW = 14, RCD = 2, RFC = 7;
`ifdef SDRAM_RESP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_RD = 4'b0101, C_WR = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        init_n = 1'b0, cke = 1'b0, ncs = 1'b1, nras = 1'b1, ncas = 1'b1, nwe = 1'b1;
    logic        dqml = 1'b0, dqmh = 1'b0, tb_oe = 1'b0;
    logic [1:0]  ba = '0;
    logic [11:0] a = '0;
    logic [15:0] tb_dq = '0;
    wire  [15:0] dq;
    logic        proto_err;
    logic [3:0]  err_code;
    logic [15:0] refresh_cnt;
    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    // released bus reads as all ones; written data never contains an 0xFF byte
    pullup (dq);
    sdram_responder #(.MEM_AW(AW), .RCD_CYC(RCD), .RFC_CYC(RFC)) dut (
        .clk(clk), .init_n(init_n), .SDRAM_CKE(cke), .SDRAM_nCS(ncs), .SDRAM_nRAS(nras),
        .SDRAM_nCAS(ncas), .SDRAM_nWE(nwe), .SDRAM_BA(ba), .SDRAM_A(a), .SDRAM_DQML(dqml),
        .SDRAM_DQMH(dqmh), .SDRAM_DQ(dq), .proto_err(proto_err), .err_code(err_code),
        .refresh_cnt(refresh_cnt)
    );
    typedef struct {
        logic [15:0] dq;
        logic        err;
        logic [3:0]  code;
        logic [15:0] rc;
        string       tag;
    } exp_t;
    exp_t q[$];
    int compared = 0, mismatched = 0;
    string tag = "reset";
    // reference model: timing expressed as edge-index differences
    bit          m_open [4];
    logic [11:0] m_row [4];
    longint      m_act [4];
    bit          m_loaded;
    int          m_cl, m_rc, rd_cl;
    longint      m_ref, n = 0, rd_k;
    logic [3:0]  m_code;
    bit          rd_v;
    logic [15:0] rd_w;
    logic [15:0] mem [int];
    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_open[i] = 1'b0;
            m_row[i]  = '0;
            m_act[i]  = -1000;
        end
        m_loaded = 1'b0;
        m_cl = 2;
        m_ref = -1000;
        m_code = '0;
        m_rc = 0;
        rd_v = 1'b0;
    endfunction
    function automatic int word_addr(input logic [1:0] b, input logic [11:0] ad);
        return int'({b, m_row[b], ad[7:0]}) % (1 << AW);
    endfunction
    function automatic void model_edge(input logic [3:0] c, input logic [1:0] b, input logic [11:0] ad,
                                       input logic [15:0] d, input logic ml, input logic mh);
        bit e [1:9];
        bit rw, act_win;
        int wa, v;
        logic [15:0] w;
        n++;
        rw = c == C_RD || c == C_WR;
        wa = word_addr(b, ad);
        act_win = rd_v && n > rd_k && n <= rd_k + rd_cl + 1;
        e[1] = c == C_LMR && !(ad[6:4] inside {3'd2, 3'd3});
        e[2] = c == C_LMR && ad[2:0] != 3'd0;
        e[3] = c == C_ACT && m_open[b];
        e[4] = rw && !m_open[b];
        e[5] = rw && n - m_act[b] < RCD;
        e[6] = rw && !m_loaded;
        e[7] = c == C_WR && act_win;
        e[8] = c == C_REF && (m_open[0] || m_open[1] || m_open[2] || m_open[3]);
        e[9] = !c[3] && c != C_NOP && n - m_ref <= RFC;
        v = 0;
        for (int i = 1; i <= 9; i++) if (e[i] && v == 0) v = i;
        if (m_code == 0) m_code = 4'(v);
        case (c)
            C_LMR: begin
                m_loaded = 1'b1;
                m_cl = (ad[6:4] == 3'd3) ? 3 : 2;
            end
            C_ACT: begin
                m_open[b] = 1'b1;
                m_row[b] = ad;
                m_act[b] = n;
            end
            C_RD: begin
                rd_v = 1'b1;
                rd_k = n;
                rd_cl = m_cl;
                rd_w = mem.exists(wa) ? mem[wa] : 16'h0;
            end
            C_WR: begin
                w = mem.exists(wa) ? mem[wa] : 16'h0;
                if (!ml) w[7:0] = d[7:0];
                if (!mh) w[15:8] = d[15:8];
                mem[wa] = w;
                if (act_win) rd_v = 1'b0;
            end
            C_PRE: if (ad[10]) for (int i = 0; i < 4; i++) m_open[i] = 1'b0; else m_open[b] = 1'b0;
            C_REF: begin
                m_rc++;
                m_ref = n;
            end
            default: ;
        endcase
        if (rw && ad[10]) m_open[b] = 1'b0;
    endfunction
    task automatic step(input logic [3:0] c, input logic [1:0] b = 2'd0, input logic [11:0] ad = 12'd0,
                        input logic [15:0] d = 16'd0, input logic ml = 1'b0, input logic mh = 1'b0,
                        input logic rst = 1'b1, input logic ck = 1'b1);
        exp_t e;
        {ncs, nras, ncas, nwe} = c;
        ba = b;
        a = ad;
        tb_dq = d;
        dqml = ml;
        dqmh = mh;
        cke = ck;
        tb_oe = c == C_WR && ck;
        init_n = rst;
        if (!rst) model_reset();
        e.dq = (rd_v && n >= rd_k + rd_cl - 1 && n <= rd_k + rd_cl) ? rd_w : (tb_oe ? d : 16'hFFFF);
        e.err = CHK && m_code != 0;
        e.code = CHK ? m_code : 4'd0;
        e.rc = 16'(m_rc);
        e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        if (rst) model_edge(ck ? c : C_NOP, b, ad, d, ml, mh);
        #1;
    endtask
    task automatic nops(input int k);
        for (int i = 0; i < k; i++) step(C_NOP);
    endtask
    task automatic chk(input string what, input logic [15:0] got, input logic [15:0] want, input string t);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s %s: got %h want %h", t, what, got, want);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("dq", dq, e.dq, e.tag);
            chk("proto_err", 16'(proto_err), 16'(e.err), e.tag);
            chk("err_code", 16'(err_code), 16'(e.code), e.tag);
            chk("refresh_cnt", refresh_cnt, e.rc, e.tag);
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int op, wa, clsel;
        logic [1:0] b;
        logic [11:0] ad, row;
        logic [15:0] d;
        bit busy, ck, ml, mh;
        model_reset();
        @(posedge clk);
        #1;
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        tag = "basic_rw";
        step(C_LMR, 0, 12'h220);
        step(C_ACT, 1, 12'd5);
        nops(2);
        step(C_WR, 1, 12'h012, 16'hBEEF);
        step(C_RD, 1, 12'h012);
        nops(4);
        tag = "byte_mask";
        step(C_WR, 1, 12'h034, 16'h1234);
        step(C_WR, 1, 12'h034, 16'hAB00, 1'b1, 1'b0);
        step(C_RD, 1, 12'h034);
        nops(4);
        tag = "rcd_violation";
        step(C_ACT, 0, 12'd5);
        step(C_RD, 0, 12'h012);
        step(C_ACT, 0, 12'd5);
        nops(4);
        tag = "refresh_checks";
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_LMR, 0, 12'h220);
        step(C_ACT, 2, 12'd1);
        step(C_NOP);
        step(C_REF);
        step(C_PRE, 0, 12'h400);
        nops(8);
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_REF);
        nops(2);
        step(C_ACT, 0, 12'd3);
        nops(8);
        tag = "write_in_window";
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_LMR, 0, 12'h230);
        step(C_ACT, 3, 12'd2);
        nops(2);
        step(C_WR, 3, 12'h007, 16'h1111);
        step(C_NOP);
        step(C_RD, 3, 12'h007);
        step(C_WR, 3, 12'h007, 16'h2222);
        nops(4);
        step(C_RD, 3, 12'h007);
        nops(5);
        tag = "reset_in_window";
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_LMR, 0, 12'h220);
        step(C_ACT, 1, 12'd5);
        nops(2);
        step(C_RD, 1, 12'h012);
        step(C_NOP);
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        step(C_ACT, 1, 12'd5);
        nops(2);
        step(C_RD, 1, 12'h012);
        nops(4);
        tag = "random";
        step(C_NOP, 0, 0, 0, 0, 0, 0);
        clsel = $urandom_range(0, 1);
        step(C_LMR, 0, clsel != 0 ? 12'h230 : 12'h220);
        nops(2);
        for (int i = 0; i < 800; i++) begin
            op = $urandom_range(0, 11);
            b = 2'($urandom_range(0, 3));
            row = 12'($urandom_range(0, 3));
            ad = {1'b0, $urandom_range(0, 3) == 0, 2'b00, 5'b0, 3'($urandom_range(0, 7))};
            d = 16'($urandom_range(0, 65535)) & 16'hFEFE;
            wa = word_addr(b, ad);
            busy = rd_v && n + 1 >= rd_k + rd_cl && n + 1 <= rd_k + rd_cl + 1;
            ck = $urandom_range(0, 19) != 0;
            ml = mem.exists(wa) && $urandom_range(0, 2) == 0;
            mh = mem.exists(wa) && $urandom_range(0, 2) == 0;
            if (op < 2) step(C_ACT, b, row, 0, 0, 0, 1, ck);
            else if (op < 5 && m_open[b] && mem.exists(wa)) step(C_RD, b, ad, 0, 0, 0, 1, ck);
            else if (op < 8 && m_open[b] && !busy) step(C_WR, b, ad, d, ml, mh, 1, ck);
            else if (op == 8) step(C_PRE, b, ad, 0, 0, 0, 1, ck);
            else if (op == 9 && $urandom_range(0, 3) == 0) step(C_REF, 0, 0, 0, 0, 0, 1, ck);
            else step(C_NOP);
        end
        nops(4);
        @(negedge clk);
        #1;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
